// File: rtl/pwm_timer.sv
// pwm_timer: multi-channel PWM generator behind a req/ready register slave.
// Optional macro PWM_TIMER_SHADOW_EN double-buffers PERIOD/DUTY until the next wrap.

module pwm_timer_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
`ifdef PWM_TIMER_SHADOW_EN
  input  logic             load,
`endif
  input  logic [CNT_W-1:0] wdata,
  input  logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] duty_rd,
  output logic             pwm
);
  logic [CNT_W-1:0] duty_act;

`ifdef PWM_TIMER_SHADOW_EN
  logic [CNT_W-1:0] duty_sh;

  // Active duty follows the shadow while idle, otherwise only at a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
    end else begin
      if (wr)          duty_sh  <= wdata;
      if (!en || load) duty_act <= duty_sh;
    end
  end

  assign duty_rd = duty_sh;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     duty_act <= '0;
    else if (wr) duty_act <= wdata;
  end

  assign duty_rd = duty_act;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= en && (count < duty_act);
  end
endmodule

module pwm_timer #(
  parameter int CH_NUM = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              ready_o,
  output logic [CH_NUM-1:0] pwm_o,
  output logic              int_sig_o
);
  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PERIOD = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_COUNT  = 8'h0C;
  localparam logic [7:0] A_DUTY   = 8'h10;

  logic [7:0]                   off;
  logic                         acc, wr;
  logic                         en, int_en, wrap;
  logic [7:0]                   presc, presc_cnt;
  logic [CNT_W-1:0]             count, period_act, period_rd;
  logic                         tick, wrap_evt;
  logic [CH_NUM-1:0]            duty_we;
  logic [CH_NUM-1:0][CNT_W-1:0] duty_rd;
  logic [31:0]                  rdata;
  logic                         unused_bits;

  assign off         = addr_i[7:0];
  assign unused_bits = ^{addr_i[31:8], data_i};

  // A held request must not re-trigger during its own ready cycle.
  assign acc = req_i && !ready_o;
  assign wr  = acc && we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en     <= 1'b0;
      int_en <= 1'b0;
      presc  <= '0;
    end else if (wr && off == A_CTRL) begin
      en     <= data_i[0];
      int_en <= data_i[1];
      presc  <= data_i[15:8];
    end
  end

`ifdef PWM_TIMER_SHADOW_EN
  logic [CNT_W-1:0] period_sh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period_sh  <= '0;
      period_act <= '0;
    end else begin
      if (wr && off == A_PERIOD) period_sh  <= data_i[CNT_W-1:0];
      if (!en || wrap_evt)       period_act <= period_sh;
    end
  end

  assign period_rd = period_sh;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      period_act <= '0;
    else if (wr && off == A_PERIOD) period_act <= data_i[CNT_W-1:0];
  end

  assign period_rd = period_act;
`endif

  // >= rather than == so a period shortened below the running count still wraps.
  assign tick     = en && (presc_cnt == presc);
  assign wrap_evt = tick && (count >= period_act);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt <= '0;
      count     <= '0;
    end else if (!en) begin
      presc_cnt <= '0;
      count     <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      count     <= wrap_evt ? '0 : count + CNT_W'(1);
    end else begin
      presc_cnt <= presc_cnt + 8'd1;
    end
  end

  // Hardware set wins over a same-cycle W1C.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    wrap <= 1'b0;
    else if (wrap_evt)                            wrap <= 1'b1;
    else if (wr && off == A_STATUS && data_i[0])  wrap <= 1'b0;
  end

  assign int_sig_o = wrap & int_en;

  for (genvar k = 0; k < CH_NUM; k++) begin : gen_ch
    assign duty_we[k] = wr && (off == A_DUTY + 8'(4 * k));

    pwm_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk_i),
      .rst     (rst_i),
      .en      (en),
      .wr      (duty_we[k]),
`ifdef PWM_TIMER_SHADOW_EN
      .load    (wrap_evt),
`endif
      .wdata   (data_i[CNT_W-1:0]),
      .count   (count),
      .duty_rd (duty_rd[k]),
      .pwm     (pwm_o[k])
    );
  end

  always_comb begin
    rdata = '0;
    case (off)
      A_CTRL:   rdata = {16'h0, presc, 6'h0, int_en, en};
      A_PERIOD: rdata[CNT_W-1:0] = period_rd;
      A_STATUS: rdata[0] = wrap;
      A_COUNT:  rdata[CNT_W-1:0] = count;
      default: begin
        for (int k = 0; k < CH_NUM; k++)
          if (off == A_DUTY + 8'(4 * k)) rdata[CNT_W-1:0] = duty_rd[k];
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_o <= 1'b0;
      data_o  <= '0;
    end else begin
      ready_o <= acc;
      data_o  <= (acc && !we_i) ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_pwm_timer.sv
// Bench for pwm_timer: register table, scoreboarded bus reads, cycle-exact PWM/IRQ checks.

module tb_pwm_timer;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        ready, int_sig;
  logic [3:0]  pwm;
  int          tests = 0, fails = 0, cyc = 0;

  typedef struct { logic chk; logic [31:0] data; string name; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; logic [31:0] r; string n; } vec_t;
  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[10];

  pwm_timer #(.CH_NUM(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .ready_o(ready), .pwm_o(pwm), .int_sig_o(int_sig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_ready: got ready with nothing pending, expected none");
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk) check(mon_e.name, rdata, mon_e.data);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output int acc_c);
    sb.push_back('{1'b0, 32'h0, "wr"});
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    acc_c = cyc; req = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{1'b1, exp, name});
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0;
    sb.delete();
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int en_c, acc_c, w, wrap_next, m, d, cb;
    logic e;

    tbl[0] = '{32'h0000_0000, 32'hFFFF_FF02, 32'h0000_FF02, "tbl_ctrl"};
    tbl[1] = '{32'h0000_0004, 32'h1234_5678, 32'h0000_5678, "tbl_period_trunc"};
    tbl[2] = '{32'h0000_0010, 32'hABCD_0001, 32'h0000_0001, "tbl_duty0"};
    tbl[3] = '{32'h0000_0014, 32'h0000_FFFF, 32'h0000_FFFF, "tbl_duty1"};
    tbl[4] = '{32'h0000_001C, 32'h0001_0010, 32'h0000_0010, "tbl_duty3"};
    tbl[5] = '{32'h0000_0020, 32'h0000_0055, 32'h0000_0000, "tbl_no_duty4"};
    tbl[6] = '{32'h0000_003C, 32'hFFFF_FFFF, 32'h0000_0000, "tbl_undef"};
    tbl[7] = '{32'h0000_000C, 32'h0000_0077, 32'h0000_0000, "tbl_count_ro"};
    tbl[8] = '{32'h0000_0008, 32'h0000_0001, 32'h0000_0000, "tbl_status"};
    tbl[9] = '{32'hFFFF_FF04, 32'h0000_0009, 32'h0000_0009, "tbl_addr_hi"};

    // Reset with a request pending: nothing may come out.
    req = 1'b1; we = 1'b0; addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ready", ready, 0);
      check("rst_dout", rdata, 0);
      check("rst_pwm_int", {pwm, int_sig}, 0);
    end
    sb.push_back('{1'b1, 32'h0, "rst_rel_rd"});
    rst = 1'b0; #1;
    check("rel_first_cycle", {rdata, ready, int_sig, pwm} == '0, 1);
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) bus_read(32'(i * 4), 32'h0, "rst_reg_zero");

    // Register table.
    for (int i = 0; i < 10; i++) begin
      bus_write(tbl[i].a, tbl[i].d, acc_c);
      bus_read(tbl[i].a, tbl[i].r, tbl[i].n);
    end
    check("tbl_pwm_idle", pwm, 0);

    // Basic PWM: period 9, duty0 3, presc 0.
    do_reset();
    bus_write(32'h04, 32'd9, acc_c);
    bus_write(32'h10, 32'd3, acc_c);
    bus_write(32'h00, 32'h1, en_c);
    for (int i = 0; i < 20; i++) begin
      e = ((cyc - 1 - en_c) % 10) < 3;
      check("basic_pwm0", pwm[0], e);
      check("basic_pwm_hi", pwm[3:1], 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin @(posedge clk); #1; end
      bus_read(32'h0C, 32'((cyc - en_c) % 10), "basic_count");
    end

    // Duty rewrite to 8 at count 5 of a period.
    m = ((cyc + 2 - en_c - 6) / 10) + 1;
    w = en_c + 10 * m + 6;
    wrap_next = en_c + 10 * (m + 1);
    wait_to(w - 1);
    bus_write(32'h10, 32'd8, acc_c);
    while (cyc <= w + 15) begin
      cb = (cyc - 1 - en_c) % 10;
`ifdef PWM_TIMER_SHADOW_EN
      d = (cyc - 1 >= wrap_next) ? 8 : 3;
`else
      d = (cyc - 1 >= w) ? 8 : 3;
`endif
      check("duty_update", pwm[0], cb < d);
      @(posedge clk); #1;
    end

    // Prescaler 2, period 4, duty 2/0/7.
    do_reset();
    bus_write(32'h00, 32'h0200, acc_c);
    bus_write(32'h04, 32'd4, acc_c);
    bus_write(32'h10, 32'd2, acc_c);
    bus_write(32'h14, 32'd0, acc_c);
    bus_write(32'h18, 32'd7, acc_c);
    bus_write(32'h00, 32'h0201, en_c);
    for (int i = 0; i < 30; i++) begin
      check("presc_pwm0", pwm[0], (((cyc - 1 - en_c) / 3) % 5) < 2);
      check("duty0_low", pwm[1], 0);
      check("duty_gt_period_high", pwm[2], 1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++)
      bus_read(32'h0C, 32'(((cyc - en_c) / 3) % 5), "presc_count");

    // Interrupt: period 3 -> wraps at edges en_c + 4j.
    do_reset();
    bus_write(32'h04, 32'd3, acc_c);
    bus_write(32'h00, 32'h3, en_c);
    wait_to(en_c + 3);
    check("int_before_wrap", int_sig, 0);
    @(posedge clk); #1;
    check("int_rise", int_sig, 1);
    w = en_c + 8;
    wait_to(w - 1);
    bus_write(32'h08, 32'h1, acc_c);
    check("w1c_vs_wrap", int_sig, 1);
    bus_read(32'h08, 32'h1, "status_kept");
    wait_to(w + 5);
    bus_write(32'h08, 32'h1, acc_c);
    check("w1c_clear", int_sig, 0);

    // Held request on an undefined offset: two pulses in four cycles.
    sb.push_back('{1'b1, 32'h0, "hold_rd0"});
    sb.push_back('{1'b1, 32'h0, "hold_rd1"});
    req = 1'b1; we = 1'b0; addr = 32'h3C;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("hold_ready", ready, (i % 2) == 1);
    end
    req = 1'b0;
    @(posedge clk); #1;

    // Reset mid-access and mid-period.
    req = 1'b1; we = 1'b0; addr = 32'h0C;
    @(posedge clk); #1;
    rst = 1'b1; req = 1'b0;
    sb.delete();
    #1;
    check("rst_drop_ready", ready, 0);
    check("rst_mid_outs", {pwm, int_sig}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(32'h0C, 32'h0, "count_after_rst");
    bus_read(32'h00, 32'h0, "ctrl_after_rst");
    bus_read(32'h04, 32'h0, "period_after_rst");
    check("pwm_after_rst", pwm, 0);

    @(posedge clk); #1;
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
